pc_sequencer: RTL and testbench

Fetch-side controller that owns the program counter register and sequences instruction fetch for the single-cycle core. It selects the next PC from sequential, branch, jump, trap and return sources by fixed priority. It drives a request/acknowledge handshake to instruction memory and a valid/ready handshake to decode. It also detects misaligned control-flow targets and redirects them to the trap vector.

---
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Fetch-side bus bundling the instruction-memory and decode handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Owns the PC, picks the next fetch address by priority and runs the
//            memory request/ack and decode valid/ready handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pc_sequencer_if.master   bus,
    input  wire logic        br_taken_i,
    input  wire logic [31:0] br_target_i,
    input  wire logic        jump_i,
    input  wire logic [31:0] jump_target_i,
    input  wire logic        trap_i,
    input  wire logic        mret_i,
    input  wire logic [31:0] epc_i,
    input  wire logic        halt_i,
    output logic [31:0]      pc_o,
    output logic             misalign_err_o,
    output logic [31:0]      bad_addr_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] bad_addr_q, bad_addr_d;

    logic        redir_any;
    logic        redir_ctl;
    logic [31:0] redir_tgt;
    logic        redir_misaligned;
    logic        epc_unused;

    assign epc_unused = &{1'b0, epc_i[1:0]};

    // Only jump/branch targets are alignment-checked; mret target is forced aligned.
    always_comb begin
        redir_any = trap_i | mret_i | jump_i | br_taken_i;
        redir_ctl = 1'b0;
        redir_tgt = '0;
        if (trap_i) begin
            redir_tgt = TRAP_VECTOR;
        end else if (mret_i) begin
            redir_tgt = {epc_i[31:2], 2'b00};
        end else if (jump_i) begin
            redir_tgt = jump_target_i;
            redir_ctl = 1'b1;
        end else if (br_taken_i) begin
            redir_tgt = br_target_i;
            redir_ctl = 1'b1;
        end
        redir_misaligned = redir_ctl && (redir_tgt[1:0] != 2'b00);
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = 1'b0;
        bad_addr_d    = bad_addr_q;

        if (state_q == S_HALT) begin
            if (trap_i) begin
                pc_d    = TRAP_VECTOR;
                state_d = S_FETCH;
            end
        end else if (redir_any) begin
            // A word acked in this same cycle belongs to the old stream and is dropped.
            state_d       = S_FETCH;
            instr_valid_d = 1'b0;
            if (redir_misaligned) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
                bad_addr_d = redir_tgt;
            end else begin
                pc_d = redir_tgt;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (halt_i) begin
                        state_d = S_HALT;
                    end else if (bus.imem_ack) begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + 32'd4;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (halt_i) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_HALT;
                    end else if (bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bad_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
            bad_addr_q    <= bad_addr_d;
        end
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign pc_o            = pc_q;
    assign misalign_err_o  = misalign_q;
    assign bad_addr_o      = bad_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed plus randomized bench for pc_sequencer against a
//            transaction-level model of the fetch sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        br_taken, jump, trap, mret, halt;
    logic [31:0] br_target, jump_target, epc;
    logic [31:0] pc, bad_addr;
    logic        misalign_err;

    int n_vec  = 0;
    int n_fail = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .trap_i         (trap),
        .mret_i         (mret),
        .epc_i          (epc),
        .halt_i         (halt),
        .pc_o           (pc),
        .misalign_err_o (misalign_err),
        .bad_addr_o     (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what the fetch unit is doing, not how it encodes it.
    bit          m_booting, m_fetching, m_have, m_halted, m_merr;
    logic [31:0] m_pc, m_instr, m_ipc, m_bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booting = 1; m_fetching = 0; m_have = 0; m_halted = 0; m_merr = 0;
        m_pc = RV; m_instr = '0; m_ipc = '0; m_bad = '0;
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        bit          any, ctl;
        any = trap | mret | jump | br_taken;
        ctl = !trap && !mret && (jump || br_taken);
        tgt = trap ? TV : mret ? (epc & ~32'h3) : jump ? jump_target : br_target;
        m_merr = 0;
        if (m_halted) begin
            if (trap) begin m_pc = TV; m_halted = 0; m_fetching = 1; end
        end else if (any) begin
            if (ctl && (tgt % 4 != 0)) begin m_pc = TV; m_merr = 1; m_bad = tgt; end
            else m_pc = tgt;
            m_booting = 0; m_have = 0; m_fetching = 1;
        end else if (m_booting) begin
            m_booting = 0; m_fetching = 1;
        end else if (halt) begin
            m_halted = 1; m_fetching = 0; m_have = 0;
        end else if (m_fetching && bus.imem_ack) begin
            m_instr = bus.imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4;
            m_fetching = 0; m_have = 1;
        end else if (m_have && bus.instr_ready) begin
            m_have = 0; m_fetching = 1;
        end
    endtask

    task automatic check_model();
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_fetching});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_have});
        chk("instr", bus.instr, m_instr);
        chk("instr_pc", bus.instr_pc, m_ipc);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_merr});
        chk("bad_addr", bad_addr, m_bad);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_update();
        @(negedge clk);
        check_model();
        bus.imem_rdata = $urandom;
    endtask

    task automatic clr_redirects();
        br_taken = 0; jump = 0; trap = 0; mret = 0; halt = 0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst pc", pc, RV);
        chk("async_rst req", {31'b0, bus.imem_req}, 32'd0);
        chk("async_rst valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("async_rst instr", bus.instr, 32'd0);
        chk("async_rst instr_pc", bus.instr_pc, 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] addr_log [5];
    logic        req_log  [5];
    logic        vld_log  [5];

    initial begin
        rst_n = 1'b0;
        clr_redirects();
        br_target = '0; jump_target = '0; epc = '0;
        bus.imem_ack = 1'b1; bus.instr_ready = 1'b1; bus.imem_rdata = 32'hDEAD_0000;
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        chk("reset pc", pc, 32'h0);
        chk("reset bad_addr", bad_addr, 32'h0);
        rst_n = 1'b1;

        // Streaming with ack/ready tied high
        for (int i = 0; i < 5; i++) begin
            step();
            addr_log[i] = bus.imem_addr; req_log[i] = bus.imem_req; vld_log[i] = bus.instr_valid;
        end
        chk("stream addr0", addr_log[0], 32'h0);
        chk("stream addr1", addr_log[2], 32'h4);
        chk("stream addr2", addr_log[4], 32'h8);
        chk("stream req0", {31'b0, req_log[0]}, 32'd1);
        chk("stream vld toggle", {28'b0, vld_log[0], vld_log[1], vld_log[2], vld_log[3]}, 32'b0101);

        // Branch while holding an unconsumed instruction
        bus.instr_ready = 0;
        step();
        chk("hold valid", {31'b0, bus.instr_valid}, 32'd1);
        br_taken = 1; br_target = 32'h40;
        step();
        clr_redirects();
        chk("br valid dropped", {31'b0, bus.instr_valid}, 32'd0);
        chk("br pc", pc, 32'h40);
        chk("br fetch addr", bus.imem_addr, 32'h40);

        // Priority and mret alignment
        trap = 1; mret = 1; jump = 1; epc = 32'h123; jump_target = 32'h500;
        step();
        chk("prio trap pc", pc, 32'h100);
        clr_redirects(); mret = 1;
        step();
        chk("mret pc", pc, 32'h120);

        // Misaligned jump
        clr_redirects(); jump = 1; jump_target = 32'h202;
        step();
        chk("misalign pulse", {31'b0, misalign_err}, 32'd1);
        chk("misalign bad", bad_addr, 32'h202);
        chk("misalign pc", pc, 32'h100);
        clr_redirects();
        step();
        chk("misalign pulse end", {31'b0, misalign_err}, 32'd0);

        // PC wrap, halt, trap resume
        bus.imem_ack = 0; jump = 1; jump_target = 32'hFFFF_FFFC;
        step();
        clr_redirects(); bus.imem_ack = 1;
        step();
        chk("wrap pc", pc, 32'h0);
        chk("wrap instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        halt = 1; bus.imem_ack = 0;
        step();
        halt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt req", {31'b0, bus.imem_req}, 32'd0);
            chk("halt pc", pc, 32'h0);
        end
        trap = 1;
        step();
        clr_redirects();
        chk("resume pc", pc, 32'h100);
        chk("resume req", {31'b0, bus.imem_req}, 32'd1);

        // Asynchronous reset mid-FETCH with ack present
        bus.imem_ack = 1;
        async_reset();
        step();
        chk("post rst fetch", bus.imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.imem_ack    = ($urandom_range(0, 2) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            trap     = ($urandom_range(0, 19) == 0);
            mret     = ($urandom_range(0, 19) == 0);
            jump     = ($urandom_range(0, 15) == 0);
            br_taken = ($urandom_range(0, 11) == 0);
            halt     = ($urandom_range(0, 29) == 0);
            epc         = $urandom;
            jump_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
            br_target   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
            if (i % 997 == 500) begin
                clr_redirects();
                async_reset();
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
